// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between an AXI4-Lite master and the axi_lite_slave_regs register bank.
// Clock and reset are not carried here; they stay plain ports on the modules.
interface axi_lite_slave_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register bank: register 0 reads STATUS_IN, the rest are R/W control words.
// Optional one-cycle GO pulse on writes to C_GO_INDEX when AXIL_SLV_GO_PULSE_EN is defined.
module axi_lite_slave_regs #(
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = 32'h40400000,
    parameter int                            C_NUM_REGS         = 32,
    parameter int                            C_GO_INDEX         = 22
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESET,
    axi_lite_slave_regs_if.slave         s_axi,
    input  logic [31:0]                  STATUS_IN,
    output logic [C_NUM_REGS*32-1:0]     REG_OUT
`ifdef AXIL_SLV_GO_PULSE_EN
    ,
    output logic                         GO
`endif
);
    localparam int IDX_W   = $clog2(C_NUM_REGS);
    localparam int TAG_LSB = IDX_W + 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [31:0]                   regs [C_NUM_REGS];
    logic                          aw_held, w_held, bvalid_q;
    logic [1:0]                    bresp_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]                   w_data_q;
    logic [3:0]                    w_strb_q;
    logic                          aw_fire, w_fire, commit;
    logic [IDX_W-1:0]              aw_idx, ar_idx;
    logic                          aw_hit, ar_hit, ar_fire;
    r_state_t                      r_state, r_next;
    logic [31:0]                   rdata_q, rdata_next;
    logic [1:0]                    rresp_q, rresp_next;

    // Ready outputs are forced low while reset is asserted, not just after it.
    assign s_axi.AWREADY = !S_AXI_ARESET && !aw_held && !bvalid_q;
    assign s_axi.WREADY  = !S_AXI_ARESET && !w_held && !bvalid_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;

    assign aw_fire = s_axi.AWVALID && s_axi.AWREADY;
    assign w_fire  = s_axi.WVALID && s_axi.WREADY;
    assign commit  = aw_held && w_held;
    assign aw_idx  = aw_addr_q[IDX_W+1:2];
    assign aw_hit  = aw_addr_q[C_S_AXI_ADDR_WIDTH-1:TAG_LSB] == C_BASEADDR[C_S_AXI_ADDR_WIDTH-1:TAG_LSB];

    // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the statement order.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_fire) begin
                aw_addr_q <= s_axi.AWADDR;
                aw_held   <= 1'b1;
            end
            if (w_fire) begin
                w_data_q <= s_axi.WDATA;
                w_strb_q <= s_axi.WSTRB;
                w_held   <= 1'b1;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= aw_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && s_axi.BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // NOTE: the bank is reset explicitly because these are control flops that user logic sees, not a RAM.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
        end else if (commit && aw_hit) begin
            for (int i = 1; i < C_NUM_REGS; i++) begin
                if (aw_idx == IDX_W'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb_q[b]) regs[i][8*b +: 8] <= w_data_q[8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg_out
        if (i == 0) begin : g_zero
            assign REG_OUT[31:0] = 32'h0;
        end else begin : g_reg
            assign REG_OUT[32*i +: 32] = regs[i];
        end
    end

`ifdef AXIL_SLV_GO_PULSE_EN
    logic go_q;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) go_q <= 1'b0;
        else              go_q <= commit && aw_hit && (aw_idx == IDX_W'(C_GO_INDEX)) && (|w_strb_q);
    end

    assign GO = go_q;
`else
    // Without the GO feature a write to C_GO_INDEX is an ordinary register write.
`endif

    assign ar_idx  = s_axi.ARADDR[IDX_W+1:2];
    assign ar_hit  = s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:TAG_LSB] == C_BASEADDR[C_S_AXI_ADDR_WIDTH-1:TAG_LSB];
    assign ar_fire = s_axi.ARVALID && s_axi.ARREADY;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) r_state <= R_IDLE;
        else              r_state <= r_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (s_axi.ARVALID) r_next = R_DATA;
            R_DATA: if (s_axi.RREADY)  r_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi.ARREADY = !S_AXI_ARESET && (r_state == R_IDLE);
        s_axi.RVALID  = (r_state == R_DATA);
    end

    // Read data is sampled from the pre-edge bank, so a same-edge write commit is not visible.
    always_comb begin
        rdata_next = 32'h0;
        rresp_next = RESP_SLVERR;
        if (ar_hit) begin
            rresp_next = RESP_OKAY;
            rdata_next = (ar_idx == '0) ? STATUS_IN : regs[ar_idx];
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_fire) begin
            rdata_q <= rdata_next;
            rresp_q <= rresp_next;
        end
    end

    assign s_axi.RDATA = rdata_q;
    assign s_axi.RRESP = rresp_q;

    logic unused_ok;
    assign unused_ok = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.ARADDR[1:0], aw_addr_q[1:0]};
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs: table of single-beat transactions plus hand-written
// sequences for write ordering, backpressure, read/write collision, GO pulse and async reset.
module tb_axi_lite_slave_regs;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   status_in = 32'h0;
    logic [1023:0] reg_out;
`ifdef AXIL_SLV_GO_PULSE_EN
    logic          go;
`endif

    int checks   = 0;
    int failures = 0;

    axi_lite_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_slave_regs dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .s_axi        (bus),
        .STATUS_IN    (status_in),
        .REG_OUT      (reg_out)
`ifdef AXIL_SLV_GO_PULSE_EN
        ,
        .GO           (go)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output int lat);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        @(negedge clk);
        bus.AWADDR = addr; bus.AWVALID = 1'b1;
        bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            @(negedge clk);
            n++;
            if (aw_hs) begin bus.AWVALID = 1'b0; aw_done = 1; end
            if (w_hs)  begin bus.WVALID = 1'b0;  w_done = 1;  end
        end
        check("wr_handshake_done", 32'(aw_done && w_done), 32'd1);
        lat = 0;
        while (!bus.BVALID && lat < 20) begin @(negedge clk); lat++; end
        resp = bus.BRESP;
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        check("bvalid_drop", 32'(bus.BVALID), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output logic rv);
        int n = 0;
        @(negedge clk);
        bus.ARADDR = addr; bus.ARVALID = 1'b1;
        while (!bus.ARREADY && n < 20) begin @(negedge clk); n++; end
        check("rd_handshake_done", 32'(n < 20), 32'd1);
        @(negedge clk);
        bus.ARVALID = 1'b0;
        rv = bus.RVALID;
        data = bus.RDATA;
        resp = bus.RRESP;
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
        check("rvalid_drop", 32'(bus.RVALID), 32'd0);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] status;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          chk_idx;
        logic [31:0] exp_reg;
    } vec_t;

    localparam int NV = 16;
    vec_t        vecs [NV];
    logic [31:0] exp_bank [32];

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        rv;
        int          lat;
        int          go_count;

        vecs[0]  = '{1, 32'h40400030, 32'h00001001, 4'hF, 32'h0,        2'b00, 32'h0,        12, 32'h00001001};
        vecs[1]  = '{1, 32'h40400034, 32'h10000000, 4'hF, 32'h0,        2'b00, 32'h0,        13, 32'h10000000};
        vecs[2]  = '{0, 32'h40400030, 32'h0,        4'h0, 32'h0,        2'b00, 32'h00001001, -1, 32'h0};
        vecs[3]  = '{1, 32'h40400008, 32'hDEADBEEF, 4'hA, 32'h0,        2'b00, 32'h0,        2,  32'hDE00BE00};
        vecs[4]  = '{0, 32'h4040000A, 32'h0,        4'h0, 32'h0,        2'b00, 32'hDE00BE00, -1, 32'h0};
        vecs[5]  = '{1, 32'h40500000, 32'h12345678, 4'hF, 32'h0,        2'b10, 32'h0,        0,  32'h0};
        vecs[6]  = '{0, 32'h40500000, 32'h0,        4'h0, 32'h0,        2'b10, 32'h0,        -1, 32'h0};
        vecs[7]  = '{0, 32'h40400000, 32'h0,        4'h0, 32'hA5A5A5A5, 2'b00, 32'hA5A5A5A5, -1, 32'h0};
        vecs[8]  = '{1, 32'h40400000, 32'hFFFFFFFF, 4'hF, 32'hA5A5A5A5, 2'b00, 32'h0,        0,  32'h0};
        vecs[9]  = '{0, 32'h40400000, 32'h0,        4'h0, 32'h5A5A0001, 2'b00, 32'h5A5A0001, -1, 32'h0};
        vecs[10] = '{1, 32'h4040007C, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00, 32'h0,        31, 32'hCAFEF00D};
        vecs[11] = '{0, 32'h4040007C, 32'h0,        4'h0, 32'h0,        2'b00, 32'hCAFEF00D, -1, 32'h0};
        vecs[12] = '{1, 32'h4040007C, 32'h00000000, 4'h0, 32'h0,        2'b00, 32'h0,        31, 32'hCAFEF00D};
        vecs[13] = '{1, 32'h40400080, 32'h55555555, 4'hF, 32'h0,        2'b10, 32'h0,        0,  32'h0};
        vecs[14] = '{0, 32'h40400FFC, 32'h0,        4'h0, 32'h0,        2'b10, 32'h0,        -1, 32'h0};
        vecs[15] = '{0, 32'h3FFFFFFC, 32'h0,        4'h0, 32'h0,        2'b10, 32'h0,        -1, 32'h0};

        for (int i = 0; i < 32; i++) exp_bank[i] = 32'h0;
        exp_bank[2]  = 32'hDE00BE00;
        exp_bank[12] = 32'h00001001;
        exp_bank[13] = 32'h10000000;
        exp_bank[31] = 32'hCAFEF00D;

        bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

        // Reset state
        #1;
        check("rst_awready", 32'(bus.AWREADY), 32'd0);
        check("rst_arready", 32'(bus.ARREADY), 32'd0);
        check("rst_bvalid",  32'(bus.BVALID),  32'd0);
        check("rst_rvalid",  32'(bus.RVALID),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_awready", 32'(bus.AWREADY), 32'd1);
        check("post_rst_wready",  32'(bus.WREADY),  32'd1);
        check("post_rst_arready", 32'(bus.ARREADY), 32'd1);
        check("post_rst_reg12",   reg_out[32*12 +: 32], 32'h0);

        for (int i = 0; i < NV; i++) begin
            status_in = vecs[i].status;
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
                check($sformatf("v%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d_b_latency", i), 32'(lat), 32'd1);
                check($sformatf("v%0d_reg%0d", i, vecs[i].chk_idx),
                      reg_out[32*vecs[i].chk_idx +: 32], vecs[i].exp_reg);
            end else begin
                do_read(vecs[i].addr, rdata, resp, rv);
                check($sformatf("v%0d_rvalid_latency", i), 32'(rv), 32'd1);
                check($sformatf("v%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            end
        end
        for (int i = 0; i < 32; i++) check($sformatf("bank_reg%0d", i), reg_out[32*i +: 32], exp_bank[i]);

        // W three cycles ahead of AW, partial strobes
        @(negedge clk);
        bus.WDATA = 32'hFFFFFFFF; bus.WSTRB = 4'b0011; bus.WVALID = 1'b1;
        @(negedge clk);
        bus.WVALID = 1'b0;
        check("early_w_wready_low", 32'(bus.WREADY), 32'd0);
        for (int k = 0; k < 2; k++) begin
            check("early_w_no_bvalid", 32'(bus.BVALID), 32'd0);
            @(negedge clk);
        end
        bus.AWADDR = 32'h40400034; bus.AWVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0;
        check("early_w_bvalid_wait", 32'(bus.BVALID), 32'd0);
        @(negedge clk);
        check("early_w_bvalid", 32'(bus.BVALID), 32'd1);
        check("early_w_bresp", 32'(bus.BRESP), 32'd0);
        check("early_w_reg13", reg_out[32*13 +: 32], 32'h1000FFFF);
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("early_w_single_bvalid", 32'(bus.BVALID), 32'd0);
            @(negedge clk);
        end

        // Write response backpressure
        bus.AWADDR = 32'h40400010; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h11112222; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_bvalid",  32'(bus.BVALID),  32'd1);
            check("bp_bresp",   32'(bus.BRESP),   32'd0);
            check("bp_awready", 32'(bus.AWREADY), 32'd0);
            check("bp_wready",  32'(bus.WREADY),  32'd0);
            @(negedge clk);
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        check("bp_bvalid_drop", 32'(bus.BVALID), 32'd0);

        // Read data backpressure
        bus.ARADDR = 32'h40400010; bus.ARVALID = 1'b1;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("rbp_rvalid",  32'(bus.RVALID),  32'd1);
            check("rbp_rdata",   bus.RDATA,        32'h11112222);
            check("rbp_rresp",   32'(bus.RRESP),   32'd0);
            check("rbp_arready", 32'(bus.ARREADY), 32'd0);
            @(negedge clk);
        end
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
        check("rbp_rvalid_drop", 32'(bus.RVALID), 32'd0);

        // Read sampled on the same edge as a write commit to the same register
        bus.AWADDR = 32'h40400010; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h33334444; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        bus.ARADDR = 32'h40400010; bus.ARVALID = 1'b1;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        check("coll_rvalid", 32'(bus.RVALID), 32'd1);
        check("coll_rdata_old", bus.RDATA, 32'h11112222);
        check("coll_bvalid", 32'(bus.BVALID), 32'd1);
        check("coll_reg4_new", reg_out[32*4 +: 32], 32'h33334444);
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;

        // GO register write
        bus.AWADDR = 32'h40400058; bus.AWVALID = 1'b1;
        bus.WDATA = 32'hFFFFFFFF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
`ifdef AXIL_SLV_GO_PULSE_EN
        check("go_before_commit", 32'(go), 32'd0);
`endif
        @(negedge clk);
        check("go_bvalid", 32'(bus.BVALID), 32'd1);
        check("go_reg22", reg_out[32*22 +: 32], 32'hFFFFFFFF);
`ifdef AXIL_SLV_GO_PULSE_EN
        check("go_pulse_high", 32'(go), 32'd1);
`endif
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
`ifdef AXIL_SLV_GO_PULSE_EN
        check("go_pulse_one_cycle", 32'(go), 32'd0);
`endif
        // Zero-strobe write to the GO register must not pulse
        bus.AWADDR = 32'h40400058; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h0; bus.WSTRB = 4'h0; bus.WVALID = 1'b1;
        go_count = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
`ifdef AXIL_SLV_GO_PULSE_EN
            if (go === 1'b1) go_count++;
`endif
        end
        bus.BREADY = 1'b0;
        check("go_zero_strb_pulses", 32'(go_count), 32'd0);
        check("go_zero_strb_reg22", reg_out[32*22 +: 32], 32'hFFFFFFFF);

        // Async reset with a write response and a read response both pending
        @(negedge clk);
        bus.AWADDR = 32'h40400020; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h00000077; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        bus.ARADDR = 32'h40400030; bus.ARVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", 32'(bus.BVALID), 32'd1);
        check("pre_rst_rvalid", 32'(bus.RVALID), 32'd1);
        check("pre_rst_rdata", bus.RDATA, 32'h00001001);
        #2 rst = 1'b1;
        #1;
        check("arst_bvalid",  32'(bus.BVALID),  32'd0);
        check("arst_rvalid",  32'(bus.RVALID),  32'd0);
        check("arst_awready", 32'(bus.AWREADY), 32'd0);
        check("arst_wready",  32'(bus.WREADY),  32'd0);
        check("arst_arready", 32'(bus.ARREADY), 32'd0);
        check("arst_rdata",   bus.RDATA,        32'h0);
        check("arst_resps",   32'({bus.BRESP, bus.RRESP}), 32'd0);
        check("arst_reg8",    reg_out[32*8 +: 32],  32'h0);
        check("arst_reg12",   reg_out[32*12 +: 32], 32'h0);
`ifdef AXIL_SLV_GO_PULSE_EN
        check("arst_go", 32'(go), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_arst_no_bvalid", 32'(bus.BVALID), 32'd0);
            check("post_arst_no_rvalid", 32'(bus.RVALID), 32'd0);
        end
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        check("post_arst_awready", 32'(bus.AWREADY), 32'd1);
        check("post_arst_reg8", reg_out[32*8 +: 32], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
